s3g_tx_arbiter: RTL and testbench

- Shares the single s3g_tx packet transmitter between NUM_REQ packet sources, e.g. executor replies and asynchronous event/status reports.
- Round-robin arbitration; captures the winner's payload into registered s3g_tx inputs and strobes packet_wr.
- Tracks the transmitter's busy handshake until the packet is sent, then reports completion to the requester.
- Sits between the packet sources and s3g_tx.

---
 rtl/s3g_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_s3g_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/s3g_tx_arbiter.sv
// rtl/s3g_tx_arbiter.sv - round-robin arbiter sharing one s3g_tx packet transmitter
// Optional S3G_TX_ARB_PRIO0_EN: requester 0 gets strict priority over the round-robin set.
module s3g_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int MAX_LEN      = 16,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*8-1:0]         req_len,
    input  logic [NUM_REQ*MAX_LEN*8-1:0] req_buf,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [NUM_REQ-1:0]           req_err,
    input  logic                         tx_busy,
    output logic                         tx_packet_wr,
    output logic [7:0]                   tx_payload_len,
    output logic [MAX_LEN*8-1:0]         tx_buf,
    output logic [2:0]                   grant_id,
    output logic                         active
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int              CNT_W     = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    state_t                 state, state_n;
    logic [2:0]             ptr, ptr_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [2:0]             grant_n;
    logic                   wr_n;
    logic [7:0]             len_n;
    logic [MAX_LEN*8-1:0]   buf_n;
    logic [NUM_REQ-1:0]     ack_n, done_n, err_n;

    logic                   found;
    logic [2:0]             win;
    logic [3:0]             idx;
    logic [NUM_REQ-1:0]     req_shift;
    logic [NUM_REQ*8-1:0]   len_shift;
    logic [NUM_REQ*MAX_LEN*8-1:0] buf_shift;
    logic [7:0]             len_sel;

    // Winner search starts one past the last winner so it is checked last.
    always_comb begin
        found     = 1'b0;
        win       = 3'd0;
        idx       = 4'd0;
        req_shift = '0;
`ifdef S3G_TX_ARB_PRIO0_EN
        if (req[0]) begin
            found = 1'b1;
            win   = 3'd0;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_REQ))
                idx = idx - 4'(NUM_REQ);
            req_shift = req >> idx;
            if (!found && req_shift[0]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

    always_comb begin
        len_shift = req_len >> (int'(win) * 8);
        buf_shift = req_buf >> (int'(win) * MAX_LEN * 8);
        len_sel   = len_shift[7:0];
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        grant_n = grant_id;
        wr_n    = 1'b0;
        len_n   = tx_payload_len;
        buf_n   = tx_buf;
        ack_n   = '0;
        done_n  = '0;
        err_n   = '0;
        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    grant_n = win;
                    len_n   = (len_sel > MAX_LEN_B) ? MAX_LEN_B : len_sel;
                    buf_n   = buf_shift[MAX_LEN*8-1:0];
                    ack_n   = NUM_REQ'(1) << win;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                wr_n    = 1'b1;
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    done_n  = NUM_REQ'(1) << grant_id;
                    err_n   = NUM_REQ'(1) << grant_id;
                    ptr_n   = grant_id;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_n  = NUM_REQ'(1) << grant_id;
                    ptr_n   = grant_id;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= 3'd0;
            cnt            <= '0;
            grant_id       <= 3'd0;
            tx_packet_wr   <= 1'b0;
            tx_payload_len <= 8'd0;
            tx_buf         <= '0;
            req_ack        <= '0;
            req_done       <= '0;
            req_err        <= '0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            cnt            <= cnt_n;
            grant_id       <= grant_n;
            tx_packet_wr   <= wr_n;
            tx_payload_len <= len_n;
            tx_buf         <= buf_n;
            req_ack        <= ack_n;
            req_done       <= done_n;
            req_err        <= err_n;
        end
    end

    assign active = (state != IDLE);

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// tb/tb_s3g_tx_arbiter.sv - directed self-checking bench for s3g_tx_arbiter
module tb_s3g_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int MAX_LEN = 16;
    localparam int BT      = 10;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*8-1:0]         req_len;
    logic [NUM_REQ*MAX_LEN*8-1:0] req_buf;
    logic [NUM_REQ-1:0]           req_ack, req_done, req_err;
    logic                         tx_busy;
    logic                         tx_packet_wr;
    logic [7:0]                   tx_payload_len;
    logic [MAX_LEN*8-1:0]         tx_buf;
    logic [2:0]                   grant_id;
    logic                         active;

    s3g_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_buf(req_buf),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .tx_busy(tx_busy),
        .tx_packet_wr(tx_packet_wr), .tx_payload_len(tx_payload_len), .tx_buf(tx_buf),
        .grant_id(grant_id), .active(active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [MAX_LEN*8-1:0] src [NUM_REQ];

    typedef struct {
        logic [1:0] req;
        logic [7:0] len0;
        logic [7:0] len1;
        logic [2:0] win_rr;
        logic [2:0] win_p0;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input logic [2:0] w);
        logic [1:0] one;
        one = 2'b01;
        return one << w;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] l);
        return (l > 8'd16) ? 8'd16 : l;
    endfunction

    task automatic finish_packet(input logic [2:0] w, input int hold);
        tick;
        chk("wr_strobe", tx_packet_wr, 1'b1);
        chk("ack_single", req_ack, 2'b00);
        tick;
        chk("wr_one_cycle", tx_packet_wr, 1'b0);
        tx_busy = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick;
            if (req_done !== 2'b00) chk("done_early", req_done, 2'b00);
        end
        chk("active_busy", active, 1'b1);
        tx_busy = 1'b0;
        tick;
        chk("done", req_done, oh(w));
        chk("err_clear", req_err, 2'b00);
        chk("idle_after", active, 1'b0);
    endtask

    task automatic run_packet(input logic [2:0] w, input logic [7:0] len, input logic hold_req, input int hold);
        tick;
        chk("ack", req_ack, oh(w));
        chk("done_quiet", req_done, 2'b00);
        chk("grant_id", grant_id, w);
        chk("payload_len", tx_payload_len, len);
        chk("tx_buf", tx_buf, src[w]);
        if (!hold_req) req = 2'b00;
        finish_packet(w, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr"}, tx_packet_wr, 1'b0);
        chk({tag, "_active"}, active, 1'b0);
        chk({tag, "_grant"}, grant_id, 3'd0);
        chk({tag, "_len"}, tx_payload_len, 8'd0);
        chk({tag, "_buf"}, tx_buf, '0);
        chk({tag, "_pulses"}, {req_ack, req_done, req_err}, 6'd0);
    endtask

    initial begin
        logic [2:0] w;
        logic [7:0] l;
        logic [2:0] cont_exp [4];

        vecs[0] = '{req: 2'b10, len0: 8'd0,  len1: 8'd5,  win_rr: 3'd1, win_p0: 3'd1};
        vecs[1] = '{req: 2'b01, len0: 8'd40, len1: 8'd5,  win_rr: 3'd0, win_p0: 3'd0};
        vecs[2] = '{req: 2'b11, len0: 8'd2,  len1: 8'd0,  win_rr: 3'd1, win_p0: 3'd0};
        vecs[3] = '{req: 2'b11, len0: 8'd16, len1: 8'd17, win_rr: 3'd0, win_p0: 3'd0};
        vecs[4] = '{req: 2'b10, len0: 8'd1,  len1: 8'd7,  win_rr: 3'd1, win_p0: 3'd1};
        src[0] = 128'h0F0E0D0C0B0A09080706050403CCBBAA;
        src[1] = 128'hF1E2D3C4B5A69788796A5B4C3D2E1F10;
        req_buf = {src[1], src[0]};

        rst_n = 1'b0; req = 2'b00; req_len = 16'd0; tx_busy = 1'b0;
        tick; tick;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single request: AA BB CC, busy held 20 cycles
        req = 2'b01; req_len = {8'd0, 8'd3};
        run_packet(3'd0, 8'd3, 1'b0, 20);
        chk("buf_low_hold", tx_buf[23:0], 24'hCCBBAA);

        for (int v = 0; v < 5; v++) begin
`ifdef S3G_TX_ARB_PRIO0_EN
            w = vecs[v].win_p0;
`else
            w = vecs[v].win_rr;
`endif
            l = (w == 3'd1) ? clamp(vecs[v].len1) : clamp(vecs[v].len0);
            req = vecs[v].req;
            req_len = {vecs[v].len1, vecs[v].len0};
            run_packet(w, l, 1'b0, 3 + v);
        end

        // Reset while tx_packet_wr is high
        req = 2'b10; req_len = {8'd4, 8'd4};
        tick;
        chk("rst1_ack", req_ack, 2'b10);
        req = 2'b00;
        tick;
        chk("rst1_wr_pre", tx_packet_wr, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst1_wr_async", tx_packet_wr, 1'b0);
        chk("rst1_active_async", active, 1'b0);
        chk("rst1_grant_async", grant_id, 3'd0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // Reset in WAIT_DONE
        req = 2'b10;
        tick;
        chk("rst2_ack", req_ack, 2'b10);
        req = 2'b00;
        tick;
        tick; tx_busy = 1'b1;
        tick; tick;
        chk("rst2_grant_pre", grant_id, 3'd1);
        chk("rst2_active_pre", active, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst2_active_async", active, 1'b0);
        chk("rst2_grant_async", grant_id, 3'd0);
        chk("rst2_wr_async", tx_packet_wr, 1'b0);
        tx_busy = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst2_no_done", {req_done, req_err, req_ack}, 6'd0);
        end

        // Contention: req held, pointer back at 0
`ifdef S3G_TX_ARB_PRIO0_EN
        cont_exp = '{3'd0, 3'd0, 3'd0, 3'd0};
`else
        cont_exp = '{3'd1, 3'd0, 3'd1, 3'd0};
`endif
        req = 2'b11; req_len = {8'd6, 8'd9};
        for (int p = 0; p < 4; p++)
            run_packet(cont_exp[p], (cont_exp[p] == 3'd1) ? 8'd6 : 8'd9, 1'b1, 2);
        req = 2'b00;
        tick;

        // Timeout: tx_busy never rises
        req = 2'b10;
        tick;
        chk("to_ack", req_ack, 2'b10);
        req = 2'b00;
        tick;
        chk("to_wr", tx_packet_wr, 1'b1);
        for (int i = 0; i < BT - 1; i++) begin
            tick;
            if (req_done !== 2'b00) chk("to_done_early", req_done, 2'b00);
        end
        tick;
        chk("to_done", req_done, 2'b10);
        chk("to_err", req_err, 2'b10);
        chk("to_idle", active, 1'b0);
        req = 2'b01;
        run_packet(3'd0, 8'd9, 1'b0, 2);

        // External busy holds off grant
        tx_busy = 1'b1; req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("ext_no_ack", {req_ack, active}, 3'd0);
        end
        tx_busy = 1'b0;
        tick;
        chk("ext_ack", req_ack, 2'b01);
        req = 2'b00;
        finish_packet(3'd0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
